stub_pair_sequencer: RTL

- Sits between stub tagging and tracklet search, consuming the per-crossing stub-count FIFO that stub tagging fills.
- For each crossing it walks every (inner stub, outer stub) address pair of the stub memories.
- It drives the inner and outer stub memory read addresses, and emits a valid/last/bx stream aligned with the memory read data.
- Tracklet search therefore sees one candidate stub pair per cycle.

---
 rtl/stub_pair_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/stub_pair_sequencer.sv
// stub_pair_sequencer: walks every (inner, outer) stub address pair per crossing.
// Ports: proc_clk/reset, count FIFO (struct_stub_cnt, empty, rd_en), hold_off,
//   stub memory addresses, pair_valid/last/bx aligned to memory data,
//   crossing_done pulse, busy, sticky cnt_clamp.
module stub_pair_sequencer #(
  parameter int ADR_BITS = 6,
  parameter int BX_BITS  = 8,
  parameter int MEM_LAT  = 2
) (
  input  logic                              proc_clk,
  input  logic                              reset,
  input  logic [BX_BITS+2*(ADR_BITS+1)-1:0] struct_stub_cnt,
  input  logic                              stub_cnt_fifo_empty,
  output logic                              stub_cnt_fifo_rd_en,
  input  logic                              hold_off,
  output logic [ADR_BITS-1:0]               in_stub_adr,
  output logic [ADR_BITS-1:0]               out_stub_adr,
  output logic                              pair_valid,
  output logic                              pair_last,
  output logic [BX_BITS-1:0]                pair_bx,
  output logic                              crossing_done,
  output logic                              busy,
  output logic                              cnt_clamp
);

  localparam int CW = ADR_BITS + 1;
  localparam logic [CW-1:0] CNT_MAX = {1'b1, {ADR_BITS{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [BX_BITS-1:0]  bx_q, bx_d;
  logic [CW-1:0]       in_cnt_q, in_cnt_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [ADR_BITS-1:0] in_adr_q, in_adr_d;
  logic [ADR_BITS-1:0] out_adr_q, out_adr_d;
  logic                clamp_q, clamp_d;
  logic                empty_done_q, empty_done_d;

  logic                issue;
  logic                last_iss;
  logic                in_end;
  logic                out_end;

  logic [CW-1:0]       raw_in;
  logic [CW-1:0]       raw_out;
  logic [BX_BITS-1:0]  raw_bx;

  logic [MEM_LAT-1:0]  vld_q;
  logic [MEM_LAT-1:0]  lst_q;
  logic [BX_BITS-1:0]  bxp_q [MEM_LAT];

  assign raw_in  = struct_stub_cnt[CW-1:0];
  assign raw_out = struct_stub_cnt[2*CW-1:CW];
  assign raw_bx  = struct_stub_cnt[2*CW +: BX_BITS];

  // Counts are >= 1 in RUN, so count-1 never underflows here.
  assign in_end  = ({1'b0, in_adr_q} == (in_cnt_q - CW'(1)));
  assign out_end = ({1'b0, out_adr_q} == (out_cnt_q - CW'(1)));

  always_comb begin
    state_d             = state_q;
    bx_d                = bx_q;
    in_cnt_d            = in_cnt_q;
    out_cnt_d           = out_cnt_q;
    in_adr_d            = in_adr_q;
    out_adr_d           = out_adr_q;
    clamp_d             = clamp_q;
    empty_done_d        = 1'b0;
    issue               = 1'b0;
    last_iss            = 1'b0;
    stub_cnt_fifo_rd_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stub_cnt_fifo_empty) begin
          stub_cnt_fifo_rd_en = 1'b1;
          state_d             = LOAD;
        end
      end
      LOAD: begin
        bx_d      = raw_bx;
        in_cnt_d  = (raw_in > CNT_MAX) ? CNT_MAX : raw_in;
        out_cnt_d = (raw_out > CNT_MAX) ? CNT_MAX : raw_out;
        if ((raw_in > CNT_MAX) || (raw_out > CNT_MAX))
          clamp_d = 1'b1;
        if ((raw_in == '0) || (raw_out == '0)) begin
          empty_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          in_adr_d  = '0;
          out_adr_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        issue    = !hold_off;
        last_iss = in_end && out_end;
        if (issue) begin
          if (last_iss) begin
            in_adr_d  = '0;
            out_adr_d = '0;
            state_d   = IDLE;
          end else if (out_end) begin
            out_adr_d = '0;
            in_adr_d  = in_adr_q + ADR_BITS'(1);
          end else begin
            out_adr_d = out_adr_q + ADR_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge proc_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bx_q         <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      in_adr_q     <= '0;
      out_adr_q    <= '0;
      clamp_q      <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      in_adr_q     <= in_adr_d;
      out_adr_q    <= out_adr_d;
      clamp_q      <= clamp_d;
      empty_done_q <= empty_done_d;
    end
  end

  // Delay line matching the stub memory read latency.
  always_ff @(posedge proc_clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      lst_q <= '0;
      for (int i = 0; i < MEM_LAT; i++)
        bxp_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      lst_q[0] <= issue & last_iss;
      bxp_q[0] <= bx_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
        bxp_q[i] <= bxp_q[i-1];
      end
    end
  end

  assign in_stub_adr   = in_adr_q;
  assign out_stub_adr  = out_adr_q;
  assign pair_valid    = vld_q[MEM_LAT-1];
  assign pair_last     = lst_q[MEM_LAT-1];
  assign pair_bx       = bxp_q[MEM_LAT-1];
  assign crossing_done = (vld_q[MEM_LAT-1] & lst_q[MEM_LAT-1]) | empty_done_q;
  assign busy          = (state_q != IDLE);
  assign cnt_clamp     = clamp_q;

endmodule
